// File: rtl/gyro_pkg.sv
// Gyro integrator shared types, constants and parameter defaults.
// Optional bias calibration is compiled in with GYRO_BIAS_CAL_EN.
package gyro_pkg;

  localparam int DEG360 = 360;

  localparam int          NUM_CH_DEF      = 3;
  localparam int          IN_W_DEF        = 16;
  localparam int          WINDOW_LOG2_DEF = 20;
  localparam int unsigned SCALE_MULT_DEF  = 43;
  localparam int          SCALE_SHIFT_DEF = 24;
  localparam int          FRAC_W_DEF      = 8;

  typedef enum logic [2:0] {
    ST_ACCUM,
    ST_SCALE,
    ST_WRAP,
    ST_PUBLISH
`ifdef GYRO_BIAS_CAL_EN
    ,
    ST_CAL
`endif
  } state_e;

endpackage

// File: rtl/gyro_channel.sv
// One rate channel: accumulate, scale, saturate, wrap, publish.
// Bias is loaded only when the top enables calibration (GYRO_BIAS_CAL_EN).
module gyro_channel
  import gyro_pkg::*;
#(
  parameter int          IN_W        = IN_W_DEF,
  parameter int          WINDOW_LOG2 = WINDOW_LOG2_DEF,
  parameter int unsigned SCALE_MULT  = SCALE_MULT_DEF,
  parameter int          SCALE_SHIFT = SCALE_SHIFT_DEF,
  parameter int          FRAC_W      = FRAC_W_DEF
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            acc_clr_i,
  input  logic            acc_en_i,
  input  logic            cal_mode_i,
  input  logic            bias_ld_i,
  input  logic            scale_en_i,
  input  logic            wrap_en_i,
  input  logic            pub_en_i,
  input  logic [IN_W-1:0] rate_i,
  output logic [8:0]      deg_o
);

  localparam int AW   = IN_W + WINDOW_LOG2 + 1;
  localparam int BW   = IN_W + 1;
  localparam int PW   = AW + 33;
  localparam int AGW  = FRAC_W + 9;
  localparam int DW   = FRAC_W + 10;
  localparam int FULL = DEG360 << FRAC_W;

  localparam logic signed [PW-1:0] MULT_S = $signed(PW'(SCALE_MULT));
  localparam logic signed [PW-1:0] LIM    = PW'(FULL - 1);
  localparam logic signed [PW-1:0] NLIM   = -LIM;
  localparam logic signed [DW-1:0] DLIM   = DW'(FULL - 1);
  localparam logic signed [DW:0]   FULL_S = (DW + 1)'(FULL);

  logic signed [AW-1:0] acc_q, acc_d, acc_nxt;
  logic signed [BW-1:0] bias_q, bias_d;
  logic signed [DW-1:0] delta_q, delta_d;
  logic [AGW-1:0]       ang_q, ang_d;
  logic [8:0]           deg_q, deg_d;
  logic signed [PW-1:0] prod, shf;
  logic signed [DW:0]   sum, wrapped;
  logic signed [IN_W-1:0] rate_s;

  assign rate_s = $signed(rate_i);

  // Window accumulator and bias capture from the final calibration sum
  always_comb begin
    if (cal_mode_i) begin
      acc_nxt = acc_q + AW'(rate_s);
    end else begin
      acc_nxt = acc_q + AW'(rate_s) - AW'(bias_q);
    end
    acc_d = acc_q;
    if (acc_clr_i) begin
      acc_d = '0;
    end else if (acc_en_i) begin
      acc_d = acc_nxt;
    end
    bias_d = bias_q;
    if (bias_ld_i) begin
      bias_d = BW'(acc_nxt >>> WINDOW_LOG2);
    end
  end

  // Scale the window sum to fixed-point degrees, clamped below one turn
  always_comb begin
    prod = PW'(acc_q) * MULT_S;
    shf  = prod >>> SCALE_SHIFT;
    if (shf > LIM) begin
      delta_d = DLIM;
    end else if (shf < NLIM) begin
      delta_d = -DLIM;
    end else begin
      delta_d = DW'(shf);
    end
  end

  // Add delta to angle and fold back once into [0, 360)
  always_comb begin
    sum = $signed({2'b00, ang_q}) + (DW + 1)'(delta_q);
    if (sum[DW]) begin
      wrapped = sum + FULL_S;
    end else if (sum >= FULL_S) begin
      wrapped = sum - FULL_S;
    end else begin
      wrapped = sum;
    end
    ang_d = wrap_en_i ? AGW'(wrapped) : ang_q;
    deg_d = pub_en_i ? ang_q[AGW-1:FRAC_W] : deg_q;
  end

  // Channel state registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q   <= '0;
      bias_q  <= '0;
      delta_q <= '0;
      ang_q   <= '0;
      deg_q   <= '0;
    end else begin
      acc_q  <= acc_d;
      bias_q <= bias_d;
      if (scale_en_i) begin
        delta_q <= delta_d;
      end
      ang_q <= ang_d;
      deg_q <= deg_d;
    end
  end

  assign deg_o = deg_q;

endmodule

// File: rtl/gyro_integrator.sv
// Multi-channel gyro rate integrator with wrapped whole-degree output.
// Define GYRO_BIAS_CAL_EN to build the bias calibration state.
module gyro_integrator
  import gyro_pkg::*;
#(
  parameter int          NUM_CH      = NUM_CH_DEF,
  parameter int          IN_W        = IN_W_DEF,
  parameter int          WINDOW_LOG2 = WINDOW_LOG2_DEF,
  parameter int unsigned SCALE_MULT  = SCALE_MULT_DEF,
  parameter int          SCALE_SHIFT = SCALE_SHIFT_DEF,
  parameter int          FRAC_W      = FRAC_W_DEF
) (
  input  logic                   clk_100mhz,
  input  logic                   rst_n_in,
  input  logic                   sample_valid,
  input  logic [NUM_CH*IN_W-1:0] rate_in,
  input  logic                   cal_start,
  output logic [NUM_CH*9-1:0]    angle_out,
  output logic                   angle_valid,
  output logic                   overrun,
  output logic                   cal_done
);

  localparam int CW = WINDOW_LOG2;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          in_cal, cal_go, accept, last, drop;
  logic          acc_clr;

`ifdef GYRO_BIAS_CAL_EN
  assign in_cal = (state_q == ST_CAL);
  assign cal_go = cal_start && (state_q == ST_ACCUM);
`else
  logic cal_unused;
  assign cal_unused = cal_start;
  assign in_cal = 1'b0;
  assign cal_go = 1'b0;
`endif

  assign accept = sample_valid &&
                  (((state_q == ST_ACCUM) && !cal_go) || in_cal);
  assign last    = accept && (&cnt_q);
  assign drop    = state_q inside {ST_SCALE, ST_WRAP, ST_PUBLISH};
  assign acc_clr = (state_q == ST_PUBLISH) || cal_go || (in_cal && last);

  // Shared sequencer: window count, phase, and registered status pulses
  always_ff @(posedge clk_100mhz) begin
    if (!rst_n_in) begin
      state_q     <= ST_ACCUM;
      cnt_q       <= '0;
      angle_valid <= 1'b0;
      overrun     <= 1'b0;
      cal_done    <= 1'b0;
    end else begin
      angle_valid <= 1'b0;
      cal_done    <= 1'b0;
      if (sample_valid && drop) begin
        overrun <= 1'b1;
      end
      unique case (state_q)
        ST_ACCUM: begin
          if (cal_go) begin
            cnt_q <= '0;
`ifdef GYRO_BIAS_CAL_EN
            state_q <= ST_CAL;
`endif
          end else if (accept) begin
            cnt_q <= cnt_q + CW'(1);
            if (last) begin
              state_q <= ST_SCALE;
            end
          end
        end
        ST_SCALE: state_q <= ST_WRAP;
        ST_WRAP:  state_q <= ST_PUBLISH;
        ST_PUBLISH: begin
          angle_valid <= 1'b1;
          cnt_q       <= '0;
          state_q     <= ST_ACCUM;
        end
`ifdef GYRO_BIAS_CAL_EN
        ST_CAL: begin
          if (accept) begin
            cnt_q <= cnt_q + CW'(1);
            if (last) begin
              cal_done <= 1'b1;
              state_q  <= ST_ACCUM;
            end
          end
        end
`endif
        default: state_q <= ST_ACCUM;
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    gyro_channel #(
      .IN_W       (IN_W),
      .WINDOW_LOG2(WINDOW_LOG2),
      .SCALE_MULT (SCALE_MULT),
      .SCALE_SHIFT(SCALE_SHIFT),
      .FRAC_W     (FRAC_W)
    ) u_ch (
      .clk_i     (clk_100mhz),
      .rst_ni    (rst_n_in),
      .acc_clr_i (acc_clr),
      .acc_en_i  (accept),
      .cal_mode_i(in_cal),
      .bias_ld_i (in_cal && last),
      .scale_en_i(state_q == ST_SCALE),
      .wrap_en_i (state_q == ST_WRAP),
      .pub_en_i  (state_q == ST_PUBLISH),
      .rate_i    (rate_in[c*IN_W +: IN_W]),
      .deg_o     (angle_out[c*9 +: 9])
    );
  end

endmodule

// File: tb/tb_gyro_integrator.sv
// Self-checking bench for gyro_integrator against a behavioural model.
// Calibration behaviour is expected only when GYRO_BIAS_CAL_EN is defined.
module tb_gyro_integrator;

  localparam int     SH   = 0;
  localparam int     N    = 16;
  localparam longint FULL = 360 * 256;

`ifdef GYRO_BIAS_CAL_EN
  localparam bit CAL_EN = 1'b1;
`else
  localparam bit CAL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, sv, cs;
  logic [47:0] rin;
  logic [26:0] ao1, ao64;
  logic        av1, av64, ov1, ov64, cd1, cd64;

  always #5 clk = ~clk;

  gyro_integrator #(
    .NUM_CH(3), .IN_W(16), .WINDOW_LOG2(4),
    .SCALE_MULT(1), .SCALE_SHIFT(SH), .FRAC_W(8)
  ) u_m1 (
    .clk_100mhz(clk), .rst_n_in(rst_n), .sample_valid(sv),
    .rate_in(rin), .cal_start(cs), .angle_out(ao1),
    .angle_valid(av1), .overrun(ov1), .cal_done(cd1)
  );

  gyro_integrator #(
    .NUM_CH(3), .IN_W(16), .WINDOW_LOG2(4),
    .SCALE_MULT(64), .SCALE_SHIFT(SH), .FRAC_W(8)
  ) u_m64 (
    .clk_100mhz(clk), .rst_n_in(rst_n), .sample_valid(sv),
    .rate_in(rin), .cal_start(cs), .angle_out(ao64),
    .angle_valid(av64), .overrun(ov64), .cal_done(cd64)
  );

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;

  longint mults[2] = '{1, 64};
  longint cur_r[3];
  longint m_sum[3], m_csum[3], m_bias[3];
  longint m_ang[2][3];
  int     m_cnt, m_ccnt, m_phase;
  bit     m_cal, m_ovr, m_vld, m_done;
  logic [26:0] m_out[2];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint scale(longint s, longint m);
    longint d;
    d = (s * m) >>> SH;
    if (d > FULL - 1) d = FULL - 1;
    else if (d < -(FULL - 1)) d = -(FULL - 1);
    return d;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_sum[c] = 0; m_csum[c] = 0; m_bias[c] = 0;
      m_ang[0][c] = 0; m_ang[1][c] = 0;
    end
    m_cnt = 0; m_ccnt = 0; m_phase = 0;
    m_cal = 0; m_ovr = 0;
    m_out[0] = '0; m_out[1] = '0;
  endtask

  task automatic model_edge(bit rst, bit v, bit cal);
    longint a;
    m_vld  = 0;
    m_done = 0;
    if (rst) begin
      model_reset();
    end else if (m_phase > 0) begin
      if (v) m_ovr = 1;
      m_phase--;
      if (m_phase == 0) begin
        m_vld = 1;
        for (int k = 0; k < 2; k++)
          for (int c = 0; c < 3; c++)
            m_out[k][c*9 +: 9] = 9'(m_ang[k][c] / 256);
      end
    end else if (m_cal) begin
      if (v) begin
        for (int c = 0; c < 3; c++) m_csum[c] += cur_r[c];
        m_ccnt++;
        if (m_ccnt == N) begin
          for (int c = 0; c < 3; c++) begin
            m_bias[c] = m_csum[c] >>> 4;
            m_sum[c]  = 0;
          end
          m_done = 1; m_cal = 0; m_cnt = 0;
        end
      end
    end else if (cal && CAL_EN) begin
      m_cal = 1; m_ccnt = 0; m_cnt = 0;
      for (int c = 0; c < 3; c++) begin
        m_csum[c] = 0; m_sum[c] = 0;
      end
    end else if (v) begin
      for (int c = 0; c < 3; c++) m_sum[c] += cur_r[c] - m_bias[c];
      m_cnt++;
      if (m_cnt == N) begin
        for (int k = 0; k < 2; k++)
          for (int c = 0; c < 3; c++) begin
            a = m_ang[k][c] + scale(m_sum[c], mults[k]);
            if (a < 0) a += FULL;
            else if (a >= FULL) a -= FULL;
            m_ang[k][c] = a;
          end
        for (int c = 0; c < 3; c++) m_sum[c] = 0;
        m_cnt = 0; m_phase = 3;
      end
    end
  endtask

  task automatic cyc(bit rst, bit v, bit cal, int r0, int r1, int r2);
    @(negedge clk);
    rst_n = !rst;
    sv    = v;
    cs    = cal;
    rin   = {16'(r2), 16'(r1), 16'(r0)};
    cur_r = '{longint'(r0), longint'(r1), longint'(r2)};
    @(posedge clk);
    model_edge(rst, v, cal);
    #1;
    chk("valid_m1", 64'(av1), 64'(m_vld));
    chk("valid_m64", 64'(av64), 64'(m_vld));
    chk("overrun_m1", 64'(ov1), 64'(m_ovr));
    chk("overrun_m64", 64'(ov64), 64'(m_ovr));
    chk("cal_done_m1", 64'(cd1), 64'(m_done));
    chk("cal_done_m64", 64'(cd64), 64'(m_done));
    chk("angle_m1", 64'(ao1), 64'(m_out[0]));
    chk("angle_m64", 64'(ao64), 64'(m_out[1]));
  endtask

  task automatic win(int n, int r0, int r1, int r2);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, r0, r1, r2);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; sv = 1'b0; cs = 1'b0; rin = '0;
    model_reset();
    m_vld = 0; m_done = 0;

    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle(1);

    win(16, 16, 0, 0);
    idle(5);

    cyc(1, 0, 0, 0, 0, 0);
    win(16, 0, -16, 0);
    idle(5);

    win(16, 0, 0, 32767);
    idle(5);

    cyc(1, 0, 0, 0, 0, 0);
    win(8, 16, 16, 16);
    cyc(1, 0, 0, 0, 0, 0);
    win(16, 16, 16, 16);
    idle(5);

    win(40, 16, 0, 0);
    idle(5);

    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 49) == 0,
          int'($urandom_range(0, 65535)) - 32768,
          int'($urandom_range(0, 65535)) - 32768,
          int'($urandom_range(0, 65535)) - 32768);
    end
    idle(5);

    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 5, 5, 5);
    win(16, 5, 5, 5);
    idle(2);
    win(16, 5, 5, 5);
    idle(5);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
